// File: rtl/board_mover.sv
// board_mover: 4x4 board player position, collected-cell tracking and per-move prize output (clk, reset, move_valid/direction/move_ready in; new_place/prize/place_valid/moves_left/collected/game_over out)
module board_mover #(
  parameter logic [3:0]  START_PLACE = 4'd0,
  parameter logic [3:0]  MAX_MOVES   = 4'd15,
  parameter logic [63:0] PRIZE_INIT  = 64'hFEDC_BA98_7654_3210
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_valid,
  input  logic [1:0]  direction,
  output logic        move_ready,
  output logic [3:0]  new_place,
  output logic [3:0]  prize,
  output logic        place_valid,
  output logic [3:0]  moves_left,
  output logic [15:0] collected,
  output logic        game_over
);
  typedef enum logic {PLAY, DONE} state_t;
  state_t state, state_n;
  logic [1:0] row, col, trow, tcol;
  logic [3:0] target, pz, left_n;
  logic [15:0] coll_n;
  logic accept;
  assign row = new_place[3:2];
  assign col = new_place[1:0];
  assign move_ready = (state == PLAY) && !reset;
  assign game_over = (state == DONE);
  assign accept = move_valid && move_ready && (moves_left != 4'd0);
  always_comb begin
    trow = direction == 2'b00 ? (row == 2'd0 ? row : row - 2'd1) :
           direction == 2'b10 ? (row == 2'd3 ? row : row + 2'd1) : row;
    tcol = direction == 2'b11 ? (col == 2'd0 ? col : col - 2'd1) :
           direction == 2'b01 ? (col == 2'd3 ? col : col + 2'd1) : col;
    target = {trow, tcol};
    pz = collected[target] ? 4'd0 : PRIZE_INIT[{target, 2'b00} +: 4];
    coll_n = collected | (16'd1 << target);
    left_n = moves_left - 4'd1;
    state_n = accept && (left_n == 4'd0 || coll_n == 16'hFFFF) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PLAY;
      new_place   <= START_PLACE;
      prize       <= 4'd0;
      place_valid <= 1'b0;
      moves_left  <= MAX_MOVES;
      collected   <= 16'd1 << START_PLACE;
    end else begin
      state       <= state_n;
      place_valid <= accept;
      if (accept) begin
        new_place  <= target;
        prize      <= pz;
        moves_left <= left_n;
        collected  <= coll_n;
      end
    end
  end
endmodule
